// File: rtl/tcd_line_scheduler.sv
// rtl/tcd_line_scheduler.sv - line-rate scheduler and config front-end for the TCD1209D timing driver
module tcd_line_scheduler #(
  parameter int PERIOD_W   = 24,
  parameter int F1_W       = 10,
  parameter int DEF_F1_CNT = 50,
  parameter int DEF_PERIOD = 600000,
  parameter int GAP_CYCLES = 16,
  parameter int HS_TIMEOUT = 64
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                cfg_wr,
  input  logic                cfg_mode,
  input  logic [F1_W-1:0]     cfg_f1_cnt,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                ext_trig,
  input  logic                clr_status,
  input  logic                drv_busy,
  output logic                line_start,
  output logic [F1_W-1:0]     f1_cnt_out,
  output logic [15:0]         line_cnt,
  output logic                overrun,
  output logic                hs_err,
  output logic                busy
);

  localparam int HS_W  = $clog2(HS_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [F1_W-1:0]     F1_MIN     = F1_W'(2);
  localparam logic [F1_W-1:0]     F1_DEF     = F1_W'(DEF_F1_CNT);
  localparam logic [PERIOD_W-1:0] PERIOD_MIN = PERIOD_W'(GAP_CYCLES + 1);
  localparam logic [PERIOD_W-1:0] PERIOD_DEF = PERIOD_W'(DEF_PERIOD);
  localparam logic [PERIOD_W-1:0] PERIOD_SAT = '1;
  localparam logic [HS_W-1:0]     HS_LAST    = HS_W'(HS_TIMEOUT - 1);
  // The RUN cycle that sees drv_busy low and the ARM cycle are idle too,
  // so GAP itself lasts GAP_CYCLES-1 cycles and line_start lands GAP_CYCLES+1 after the fall.
  localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'(GAP_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    START = 3'd2,
    HS    = 3'd3,
    RUN   = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t state, next_state;

  logic                sh_mode;
  logic [F1_W-1:0]     sh_f1;
  logic [PERIOD_W-1:0] sh_period;
  logic                act_mode;
  logic [PERIOD_W-1:0] act_period;

  logic [PERIOD_W-1:0] period_cnt;
  logic [HS_W-1:0]     hs_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic                first_line;

  logic trig_s1, trig_s2, trig_s3, trig_evt;

  logic [PERIOD_W-1:0] period_m1;
  logic                period_hit;
  logic                period_now;
  logic                in_line;
  logic                overrun_set;
  logic                hs_err_set;
  logic                load_act;

  assign period_m1  = act_period - PERIOD_W'(1);
  assign period_hit = (period_cnt >= period_m1);
  assign period_now = (period_cnt == period_m1);
  assign in_line    = (state == HS) || (state == RUN) || (state == GAP);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (enable) next_state = ARM;
      ARM: begin
        if (!enable)
          next_state = IDLE;
        else if (act_mode ? trig_evt : (first_line || period_hit))
          next_state = START;
      end
      START: next_state = HS;
      HS: begin
        if (drv_busy)
          next_state = RUN;
        else if (hs_cnt == HS_LAST)
          next_state = ARM;
      end
      RUN:   if (!drv_busy) next_state = GAP;
      GAP:   if (gap_cnt == GAP_LAST) next_state = enable ? ARM : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Deferred free-run lines need no extra state: period_hit stays true in ARM.
  assign overrun_set = act_mode ? (trig_evt && (state != IDLE) && (state != ARM))
                                : (period_now && in_line);
  assign hs_err_set  = (state == HS) && !drv_busy && (hs_cnt == HS_LAST);
  assign load_act    = (next_state == START) || ((state == IDLE) && enable);

  assign line_start = (state == START);
  assign busy       = (state != IDLE);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sh_mode    <= 1'b0;
      sh_f1      <= F1_DEF;
      sh_period  <= PERIOD_DEF;
      act_mode   <= 1'b0;
      f1_cnt_out <= F1_DEF;
      act_period <= PERIOD_DEF;
      period_cnt <= '0;
      hs_cnt     <= '0;
      gap_cnt    <= '0;
      first_line <= 1'b0;
      line_cnt   <= '0;
      overrun    <= 1'b0;
      hs_err     <= 1'b0;
      trig_s1    <= 1'b0;
      trig_s2    <= 1'b0;
      trig_s3    <= 1'b0;
      trig_evt   <= 1'b0;
    end else begin
      state <= next_state;

      if (cfg_wr) begin
        sh_mode   <= cfg_mode;
        sh_f1     <= (cfg_f1_cnt < F1_MIN) ? F1_MIN : cfg_f1_cnt;
        sh_period <= (cfg_period < PERIOD_MIN) ? PERIOD_MIN : cfg_period;
      end

      // Old shadow wins over a coincident cfg_wr by non-blocking semantics.
      if (load_act) begin
        act_mode   <= sh_mode;
        f1_cnt_out <= sh_f1;
        act_period <= sh_period;
      end

      if (next_state == START)
        period_cnt <= '0;
      else if (period_cnt != PERIOD_SAT)
        period_cnt <= period_cnt + PERIOD_W'(1);

      // hs_cnt holds cycles since line_start, so hs_err rises HS_TIMEOUT cycles after it.
      if (state == START)
        hs_cnt <= HS_W'(1);
      else if (state == HS)
        hs_cnt <= hs_cnt + HS_W'(1);

      if (state == GAP)
        gap_cnt <= gap_cnt + GAP_W'(1);
      else
        gap_cnt <= '0;

      if ((state == IDLE) && enable)
        first_line <= 1'b1;
      else if (state == START)
        first_line <= 1'b0;

      if (state == START)
        line_cnt <= line_cnt + 16'd1;

      if (overrun_set)
        overrun <= 1'b1;
      else if (clr_status)
        overrun <= 1'b0;

      if (hs_err_set)
        hs_err <= 1'b1;
      else if (clr_status)
        hs_err <= 1'b0;

      trig_s1  <= ext_trig;
      trig_s2  <= trig_s1;
      trig_s3  <= trig_s2;
      trig_evt <= trig_s2 & ~trig_s3;
    end
  end

endmodule
